// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: captures the decoded instruction, operands and extended immediate,
// and inserts a one-cycle bubble on load-use hazards. Optional macro: BRANCH_TARGET_EN.
module id_ex_pipe_reg #(
    parameter int unsigned DW    = 32,
    parameter logic [5:0]  LW_OP = 6'b100011
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [31:0]   id_instr,
    input  logic [DW-1:0] id_pc_plus4,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [1:0]    id_ext_sel,
    input  logic          stall,
    input  logic          flush,
    output logic          hazard_stall,
    output logic          ex_valid,
    output logic [5:0]    ex_opcode,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [4:0]    ex_shamt,
    output logic [5:0]    ex_funct,
    output logic [DW-1:0] ex_imm32,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_pc_plus4,
    output logic          ex_mem_read,
    output logic [DW-1:0] ex_br_target
);

    typedef enum logic [1:0] {
        ExtSign = 2'b00,
        ExtZero = 2'b01,
        ExtLui  = 2'b10,
        ExtAlt  = 2'b11
    } ext_sel_e;

    logic          valid_q, valid_d;
    logic [31:0]   instr_q, instr_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] pc4_q, pc4_d;

    logic [15:0]   id_imm;
    logic [DW-1:0] imm_sext;
    logic [DW-1:0] imm_ext;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;

    assign id_imm   = id_instr[15:0];
    assign id_rs    = id_instr[25:21];
    assign id_rt    = id_instr[20:16];
    assign imm_sext = {{(DW-16){id_imm[15]}}, id_imm};

    always_comb begin
        imm_ext = imm_sext;
        case (ext_sel_e'(id_ext_sel))
            ExtZero: imm_ext = {{(DW-16){1'b0}}, id_imm};
            ExtLui:  imm_ext = {id_imm, {(DW-16){1'b0}}};
            default: imm_ext = imm_sext;
        endcase
    end

    // Decode of the held instruction.
    assign ex_valid    = valid_q;
    assign ex_opcode   = instr_q[31:26];
    assign ex_rs       = instr_q[25:21];
    assign ex_rt       = instr_q[20:16];
    assign ex_rd       = instr_q[15:11];
    assign ex_shamt    = instr_q[10:6];
    assign ex_funct    = instr_q[5:0];
    assign ex_imm32    = imm_q;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_pc_plus4 = pc4_q;
    assign ex_mem_read = valid_q & (instr_q[31:26] == LW_OP);

    // A load into $0 never creates a real dependency.
    assign hazard_stall = ex_mem_read & id_valid & (ex_rt != 5'd0) &
                          ((ex_rt == id_rs) | (ex_rt == id_rt));

    logic do_bubble;
    logic do_load;

    always_comb begin
        do_bubble = 1'b0;
        do_load   = 1'b0;
        if (flush) begin
            do_bubble = 1'b1;
        end else if (stall) begin
            do_bubble = 1'b0;
        end else if (hazard_stall) begin
            do_bubble = 1'b1;
        end else begin
            do_load = 1'b1;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        pc4_d     = pc4_q;
        if (do_bubble) begin
            valid_d   = 1'b0;
            instr_d   = '0;
            imm_d     = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            pc4_d     = '0;
        end else if (do_load) begin
            valid_d   = id_valid;
            instr_d   = id_instr;
            imm_d     = imm_ext;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            pc4_d     = id_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            imm_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            pc4_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            pc4_q     <= pc4_d;
        end
    end

`ifdef BRANCH_TARGET_EN
    logic [DW-1:0] br_q, br_d;

    // Always sign-extended, independent of id_ext_sel; wraps mod 2^DW.
    always_comb begin
        br_d = br_q;
        if (do_bubble) begin
            br_d = '0;
        end else if (do_load) begin
            br_d = id_pc_plus4 + {imm_sext[DW-3:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_q <= '0;
        end else begin
            br_q <= br_d;
        end
    end

    assign ex_br_target = br_q;
`else
    assign ex_br_target = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: vector tables, hand sequences and a random run
// compared against a behavioural model of the stage. Honours BRANCH_TARGET_EN.
module tb_id_ex_pipe_reg;

    localparam logic [5:0] LW = 6'b100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr, id_pc_plus4, id_rs_data, id_rt_data;
    logic [1:0]  id_ext_sel;
    logic        stall, flush;
    logic        hazard_stall, ex_valid, ex_mem_read;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [31:0] ex_imm32, ex_rs_data, ex_rt_data, ex_pc_plus4, ex_br_target;

    id_ex_pipe_reg #(.DW(32), .LW_OP(LW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_ext_sel(id_ext_sel), .stall(stall), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_funct(ex_funct), .ex_imm32(ex_imm32), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_pc_plus4(ex_pc_plus4), .ex_mem_read(ex_mem_read),
        .ex_br_target(ex_br_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [1:0]  sel;
        logic        stall;
        logic        flush;
    } in_t;

    // Expected contents of the EX slot.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [31:0] br;
    } ex_t;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  sel;
        logic [31:0] exp;
    } ext_vec_t;

    int   n_vec = 0;
    int   n_miss = 0;
    ex_t  exp_q = '0;
    logic hz_seen;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        int v;
        v = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
        return 32'(v);
    endfunction

    function automatic logic model_hazard(input ex_t cur, input in_t v);
        logic [4:0] dst;
        dst = cur.instr[20:16];
        return cur.valid && (cur.instr[31:26] == LW) && v.valid && (dst != 0) &&
               (dst == v.instr[25:21] || dst == v.instr[20:16]);
    endfunction

    function automatic ex_t model_next(input ex_t cur, input in_t v);
        ex_t n;
        logic [15:0] imm;
        if (!v.rst_n || v.flush) return '0;
        if (v.stall) return cur;
        if (model_hazard(cur, v)) return '0;
        imm     = v.instr[15:0];
        n.valid = v.valid;
        n.instr = v.instr;
        n.rs    = v.rs;
        n.rt    = v.rt;
        n.pc    = v.pc;
        if (v.sel == 2'b01)      n.imm = 32'(imm);
        else if (v.sel == 2'b10) n.imm = 32'(imm) * 32'd65536;
        else                     n.imm = sext16(imm);
`ifdef BRANCH_TARGET_EN
        n.br = v.pc + sext16(imm) * 32'd4;
`else
        n.br = 32'h0;
`endif
        return n;
    endfunction

    function automatic in_t mk(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [1:0] sel);
        in_t v;
        v.rst_n = 1'b1;
        v.valid = valid;
        v.instr = instr;
        v.pc    = pc;
        v.rs    = pc ^ 32'h1111_0000;
        v.rt    = pc ^ 32'h0000_2222;
        v.sel   = sel;
        v.stall = 1'b0;
        v.flush = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", 32'(ex_valid), 32'(exp_q.valid));
        check("ex_opcode", 32'(ex_opcode), 32'(exp_q.instr[31:26]));
        check("ex_rs", 32'(ex_rs), 32'(exp_q.instr[25:21]));
        check("ex_rt", 32'(ex_rt), 32'(exp_q.instr[20:16]));
        check("ex_rd", 32'(ex_rd), 32'(exp_q.instr[15:11]));
        check("ex_shamt", 32'(ex_shamt), 32'(exp_q.instr[10:6]));
        check("ex_funct", 32'(ex_funct), 32'(exp_q.instr[5:0]));
        check("ex_imm32", ex_imm32, exp_q.imm);
        check("ex_rs_data", ex_rs_data, exp_q.rs);
        check("ex_rt_data", ex_rt_data, exp_q.rt);
        check("ex_pc_plus4", ex_pc_plus4, exp_q.pc);
        check("ex_mem_read", 32'(ex_mem_read),
              32'(exp_q.valid && exp_q.instr[31:26] == LW));
        check("ex_br_target", ex_br_target, exp_q.br);
    endtask

    // Drive one cycle of ID inputs, check the combinational hazard, clock, check the slot.
    task automatic step(input in_t v);
        rst_n       = v.rst_n;
        id_valid    = v.valid;
        id_instr    = v.instr;
        id_pc_plus4 = v.pc;
        id_rs_data  = v.rs;
        id_rt_data  = v.rt;
        id_ext_sel  = v.sel;
        stall       = v.stall;
        flush       = v.flush;
        #1;
        hz_seen = hazard_stall;
        if (v.rst_n) check("hazard_stall", 32'(hazard_stall), 32'(model_hazard(exp_q, v)));
        @(posedge clk);
        exp_q = model_next(exp_q, v);
        #1;
        check_outputs();
    endtask

    initial begin
        ext_vec_t    ext_tbl[5];
        in_t         v;
        logic [31:0] lw5, add_dep, lw0, add_r0, held_pc, br_exp;

        ext_tbl[0] = '{16'hFBFF, 2'b00, 32'hFFFFFBFF};
        ext_tbl[1] = '{16'hFBFF, 2'b01, 32'h0000FBFF};
        ext_tbl[2] = '{16'hFBFF, 2'b10, 32'hFBFF0000};
        ext_tbl[3] = '{16'h000D, 2'b00, 32'h0000000D};
        ext_tbl[4] = '{16'h8000, 2'b11, 32'hFFFF8000};

        lw5     = 32'h8C250004;  // lw  $5,4($1)
        add_dep = 32'h00A23820;  // add $7,$5,$2
        lw0     = 32'h8C200004;  // lw  $0,4($1)
        add_r0  = 32'h00023820;  // add $7,$0,$2

        // Reset held for two edges while ID presents a valid instruction.
        v = mk(1'b1, 32'h2001_0005, 32'h0040_0004, 2'b00);
        v.rst_n = 1'b0;
        step(v);
        step(v);
        check("rst_valid", 32'(ex_valid), 32'h0);
        check("rst_pc", ex_pc_plus4, 32'h0);

        // Immediate extension.
        for (int i = 0; i < 5; i++) begin
            step(mk(1'b1, {16'h2408, ext_tbl[i].imm}, 32'h100 + 32'(i * 4), ext_tbl[i].sel));
            check("ext_imm32", ex_imm32, ext_tbl[i].exp);
        end

        // Load-use: one hazard cycle, one bubble, then the dependent add.
        step(mk(1'b1, lw5, 32'h0040_0020, 2'b00));
        check("lu_memread", 32'(ex_mem_read), 32'h1);
        step(mk(1'b1, add_dep, 32'h0040_0024, 2'b00));
        check("lu_hazard", 32'(hz_seen), 32'h1);
        check("lu_bubble", 32'(ex_valid), 32'h0);
        step(mk(1'b1, add_dep, 32'h0040_0024, 2'b00));
        check("lu_hazard_clear", 32'(hz_seen), 32'h0);
        check("lu_add_valid", 32'(ex_valid), 32'h1);
        check("lu_add_rs", 32'(ex_rs), 32'd5);

        // Load into $0 never stalls.
        step(mk(1'b1, lw0, 32'h0040_0030, 2'b00));
        step(mk(1'b1, add_r0, 32'h0040_0034, 2'b00));
        check("lw0_hazard", 32'(hz_seen), 32'h0);
        check("lw0_add_valid", 32'(ex_valid), 32'h1);

        // Stall and hazard together: hold, hazard stays asserted.
        step(mk(1'b1, lw5, 32'h0040_0040, 2'b00));
        v = mk(1'b1, add_dep, 32'h0040_0044, 2'b00);
        v.stall = 1'b1;
        step(v);
        check("sh_hazard", 32'(hz_seen), 32'h1);
        check("sh_hold", ex_pc_plus4, 32'h0040_0040);
        // Flush and hazard together: one bubble.
        v.stall = 1'b0;
        v.flush = 1'b1;
        step(v);
        check("fh_bubble", 32'(ex_valid), 32'h0);

        // Stall for three edges with changing inputs.
        step(mk(1'b1, 32'h3C01_1234, 32'h0040_0050, 2'b10));
        held_pc = ex_pc_plus4;
        for (int i = 0; i < 3; i++) begin
            v = mk(1'b1, 32'h2002_0000 + 32'(i), 32'h0050_0000 + 32'(i * 4), 2'b00);
            v.stall = 1'b1;
            step(v);
            check("stall_pc", ex_pc_plus4, 32'h0040_0050);
            check("stall_imm", ex_imm32, 32'h1234_0000);
        end
        // Flush with a valid instruction; then flush with stall.
        v = mk(1'b1, 32'h2003_7777, 32'h0040_0060, 2'b00);
        v.flush = 1'b1;
        step(v);
        check("flush_valid", 32'(ex_valid), 32'h0);
        check("flush_imm", ex_imm32, 32'h0);
        step(mk(1'b1, 32'h2003_7777, 32'h0040_0064, 2'b00));
        v.stall = 1'b1;
        step(v);
        check("flush_stall_valid", 32'(ex_valid), 32'h0);
        check("flush_stall_pc", ex_pc_plus4, 32'h0);

        // Branch target.
        step(mk(1'b1, 32'h1000_FFFF, 32'h0040_0010, 2'b01));
`ifdef BRANCH_TARGET_EN
        br_exp = 32'h0040_000C;
`else
        br_exp = 32'h0;
`endif
        check("br_back", ex_br_target, br_exp);
        step(mk(1'b1, 32'h1000_0002, 32'hFFFF_FFFC, 2'b10));
`ifdef BRANCH_TARGET_EN
        br_exp = 32'h0000_0004;
`else
        br_exp = 32'h0;
`endif
        check("br_wrap", ex_br_target, br_exp);

        // Back-to-back stream of eight independent instructions.
        for (int i = 0; i < 8; i++) begin
            step(mk(1'b1, 32'h0000_0020 | (32'(i) << 11), 32'h0040_1000 + 32'(i * 4), 2'b00));
            check("stream_valid", 32'(ex_valid), 32'h1);
            check("stream_pc", ex_pc_plus4, 32'h0040_1000 + 32'(i * 4));
        end

        // Reset in the middle of a hazard.
        step(mk(1'b1, lw5, 32'h0040_2000, 2'b00));
        v = mk(1'b1, add_dep, 32'h0040_2004, 2'b00);
        v.rst_n = 1'b0;
        step(v);
        check("rst_mid_valid", 32'(ex_valid), 32'h0);

        // Random traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 2) == 0) ins[31:26] = LW;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            v.rst_n = ($urandom_range(0, 49) != 0);
            v.valid = ($urandom_range(0, 4) != 0);
            v.instr = ins;
            v.pc    = $urandom;
            v.rs    = $urandom;
            v.rt    = $urandom;
            v.sel   = 2'($urandom_range(0, 3));
            v.stall = ($urandom_range(0, 7) == 0);
            v.flush = ($urandom_range(0, 9) == 0);
            step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
